fc_mac_engine: RTL

- Parametrised fully-connected compute engine; next generation after the fixed 120→84 FC block.
- Computes N_LANE output neurons per tile against a shared input vector, looping over tiles until the whole layer is done.
- Requantises each result with a rounding right shift, optional ReLU and OUT_W saturation.
- Emits results one per cycle over a valid/ready stream with a last flag; sits between the ifmap/weight buffers and the next layer's ifmap writer.

---
 rtl/fc_mac_if.sv | 41 ++++
 rtl/fc_mac_engine.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/fc_mac_if.sv
// Stream and buffer-port bundle for the fully-connected MAC engine.
// master = engine side, slave = environment (buffers, controller, next-layer writer).
interface fc_mac_if #(
    parameter int unsigned DATA_W  = 8,
    parameter int unsigned N_LANE  = 4,
    parameter int unsigned IN_MAX  = 1024,
    parameter int unsigned OUT_MAX = 128,
    parameter int unsigned OUT_W   = 8,
    parameter int unsigned WADDR_W = 17
);
    localparam int unsigned IN_AW  = $clog2(IN_MAX);
    localparam int unsigned OUT_AW = $clog2(OUT_MAX + 1);

    logic                       start_i;
    logic [IN_AW:0]             in_node_num_i;
    logic [OUT_AW-1:0]          out_node_num_i;
    logic [4:0]                 shift_i;
    logic                       relu_en_i;
    logic                       busy_o;
    logic [IN_AW-1:0]           ifmap_rdaddr_o;
    logic [DATA_W-1:0]          ifmap_rdata_i;
    logic [WADDR_W-1:0]         wbuf_rdaddr_o;
    logic [N_LANE*DATA_W-1:0]   wbuf_rdata_i;
    logic [OUT_W-1:0]           result_o;
    logic                       valid_o;
    logic                       ready_i;
    logic                       last_o;
    logic                       done_o;

    modport master (
        input  start_i, in_node_num_i, out_node_num_i, shift_i, relu_en_i,
        input  ifmap_rdata_i, wbuf_rdata_i, ready_i,
        output busy_o, ifmap_rdaddr_o, wbuf_rdaddr_o, result_o, valid_o, last_o, done_o
    );

    modport slave (
        output start_i, in_node_num_i, out_node_num_i, shift_i, relu_en_i,
        output ifmap_rdata_i, wbuf_rdata_i, ready_i,
        input  busy_o, ifmap_rdaddr_o, wbuf_rdaddr_o, result_o, valid_o, last_o, done_o
    );
endinterface

// File: rtl/fc_mac_engine.sv
// Tiled fully-connected layer engine: N_LANE neurons per tile share one ifmap stream,
// results are requantised (round-shift, ReLU, saturate) and streamed out one per cycle.
module fc_mac_engine #(
    parameter int unsigned DATA_W  = 8,
    parameter int unsigned N_LANE  = 4,
    parameter int unsigned IN_MAX  = 1024,
    parameter int unsigned OUT_MAX = 128,
    parameter int unsigned ACC_W   = 24,
    parameter int unsigned OUT_W   = 8,
    parameter int unsigned WADDR_W = 17
) (
    input  logic     clk,
    input  logic     rst,
    fc_mac_if.master bus
);
    localparam int unsigned IN_AW  = $clog2(IN_MAX);
    localparam int unsigned OUT_AW = $clog2(OUT_MAX + 1);
    localparam int unsigned LANE_W = $clog2(N_LANE + 1);
    localparam int unsigned PROD_W = 2 * DATA_W;
    localparam int unsigned RQ_W   = ACC_W + 33;
    localparam logic signed [RQ_W-1:0] SAT_MAX = RQ_W'((2 ** (OUT_W - 1)) - 1);
    localparam logic signed [RQ_W-1:0] SAT_MIN = ~SAT_MAX;

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_DRAIN, S_EMIT, S_DONE} state_e;

    state_e                    state_q, state_d;
    logic [IN_AW:0]            in_num_q, in_num_d;
    logic [OUT_AW-1:0]         out_num_q, out_num_d;
    logic [4:0]                shift_q, shift_d;
    logic                      relu_q, relu_d;
    logic [IN_AW-1:0]          rd_addr_q, rd_addr_d;
    logic [WADDR_W-1:0]        waddr_q, waddr_d;
    logic                      rd_vld_q, rd_vld_d;
    logic [LANE_W-1:0]         lane_q, lane_d;
    logic [OUT_AW-1:0]         out_idx_q, out_idx_d;
    logic signed [ACC_W-1:0]   acc_q [N_LANE];
    logic signed [ACC_W-1:0]   acc_d [N_LANE];
    logic                      busy_q, busy_d;
    logic                      done_q, done_d;
    logic                      valid_q, valid_d;
    logic                      last_q, last_d;
    logic [OUT_W-1:0]          result_q, result_d;

    logic signed [DATA_W-1:0]  x_s;
    logic signed [DATA_W-1:0]  w_s;
    logic signed [PROD_W-1:0]  prod [N_LANE];
    logic signed [ACC_W-1:0]   sel_acc;

    // Round-half-up arithmetic shift, then optional ReLU, then clamp to OUT_W.
    function automatic logic [OUT_W-1:0] requant(input logic signed [ACC_W-1:0] a,
                                                 input logic [4:0] s, input logic relu);
        logic signed [RQ_W-1:0] r;
        logic signed [RQ_W-1:0] rnd;
        r   = RQ_W'(a);
        rnd = '0;
        if (s != 5'd0) begin
            rnd = RQ_W'(1) << (s - 5'd1);
            r   = (r + rnd) >>> s;
        end
        if (relu && (r < 0)) r = '0;
        if (r > SAT_MAX) r = SAT_MAX;
        else if (r < SAT_MIN) r = SAT_MIN;
        return OUT_W'(r);
    endfunction

    assign x_s = bus.ifmap_rdata_i;

    always_comb begin
        w_s = '0;
        for (int l = 0; l < N_LANE; l++) begin
            w_s     = bus.wbuf_rdata_i[l*DATA_W +: DATA_W];
            prod[l] = PROD_W'(w_s) * PROD_W'(x_s);
        end
    end

    always_comb begin
        sel_acc = '0;
        for (int l = 0; l < N_LANE; l++) begin
            if (lane_q == LANE_W'(l)) sel_acc = acc_q[l];
        end
    end

    always_comb begin
        state_d   = state_q;
        in_num_d  = in_num_q;
        out_num_d = out_num_q;
        shift_d   = shift_q;
        relu_d    = relu_q;
        rd_addr_d = rd_addr_q;
        waddr_d   = waddr_q;
        rd_vld_d  = (state_q == S_LOAD);
        lane_d    = lane_q;
        out_idx_d = out_idx_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        valid_d   = valid_q;
        last_d    = last_q;
        result_d  = result_q;
        for (int l = 0; l < N_LANE; l++) begin
            acc_d[l] = acc_q[l];
            if (rd_vld_q) acc_d[l] = acc_q[l] + ACC_W'(prod[l]);
        end

        case (state_q)
            S_IDLE: begin
                if (bus.start_i) begin
                    in_num_d  = bus.in_node_num_i;
                    out_num_d = bus.out_node_num_i;
                    shift_d   = bus.shift_i;
                    relu_d    = bus.relu_en_i;
                    busy_d    = 1'b1;
                    rd_addr_d = '0;
                    waddr_d   = '0;
                    out_idx_d = '0;
                    if ((bus.in_node_num_i == '0) || (bus.out_node_num_i == '0)) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = S_LOAD;
                        for (int l = 0; l < N_LANE; l++) acc_d[l] = '0;
                    end
                end
            end
            S_LOAD: begin
                // Weight address keeps running across tiles: tile*in + k.
                waddr_d = waddr_q + WADDR_W'(1);
                if ({1'b0, rd_addr_q} == (in_num_q - (IN_AW + 1)'(1))) begin
                    state_d = S_DRAIN;
                end else begin
                    rd_addr_d = rd_addr_q + IN_AW'(1);
                end
            end
            S_DRAIN: begin
                state_d = S_EMIT;
                lane_d  = '0;
            end
            S_EMIT: begin
                // Output register refills whenever it is empty or being drained.
                if (!valid_q || bus.ready_i) begin
                    if ((lane_q != LANE_W'(N_LANE)) && (out_idx_q != out_num_q)) begin
                        result_d  = requant(sel_acc, shift_q, relu_q);
                        valid_d   = 1'b1;
                        last_d    = (out_idx_q == (out_num_q - OUT_AW'(1)));
                        lane_d    = lane_q + LANE_W'(1);
                        out_idx_d = out_idx_q + OUT_AW'(1);
                    end else begin
                        valid_d = 1'b0;
                        last_d  = 1'b0;
                        if (valid_q) begin
                            if (out_idx_q != out_num_q) begin
                                state_d   = S_LOAD;
                                rd_addr_d = '0;
                                for (int l = 0; l < N_LANE; l++) acc_d[l] = '0;
                            end else begin
                                state_d = S_DONE;
                                done_d  = 1'b1;
                            end
                        end
                    end
                end
            end
            S_DONE: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            in_num_q  <= '0;
            out_num_q <= '0;
            shift_q   <= '0;
            relu_q    <= 1'b0;
            rd_addr_q <= '0;
            waddr_q   <= '0;
            rd_vld_q  <= 1'b0;
            lane_q    <= '0;
            out_idx_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            valid_q   <= 1'b0;
            last_q    <= 1'b0;
            result_q  <= '0;
            for (int l = 0; l < N_LANE; l++) acc_q[l] <= '0;
        end else begin
            state_q   <= state_d;
            in_num_q  <= in_num_d;
            out_num_q <= out_num_d;
            shift_q   <= shift_d;
            relu_q    <= relu_d;
            rd_addr_q <= rd_addr_d;
            waddr_q   <= waddr_d;
            rd_vld_q  <= rd_vld_d;
            lane_q    <= lane_d;
            out_idx_q <= out_idx_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            valid_q   <= valid_d;
            last_q    <= last_d;
            result_q  <= result_d;
            for (int l = 0; l < N_LANE; l++) acc_q[l] <= acc_d[l];
        end
    end

    assign bus.busy_o         = busy_q;
    assign bus.done_o         = done_q;
    assign bus.valid_o        = valid_q;
    assign bus.last_o         = last_q;
    assign bus.result_o       = result_q;
    assign bus.ifmap_rdaddr_o = rd_addr_q;
    assign bus.wbuf_rdaddr_o  = waddr_q;
endmodule
